// File: rtl/odd_parity_pkg.sv
// Shared definitions for the serial odd-parity link: default width, frame
// state encoding and the reference parity function.
package odd_parity_pkg;

    localparam int DATA_W_DEF = 3;

    typedef enum logic {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_t;

    // Parity bit that makes the whole frame contain an odd number of ones.
    function automatic logic odd_parity_bit(input logic [DATA_W_DEF-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/odd_parity_checker_if.sv
// Word-level side of the odd-parity receiver: serial bit input, frame abort
// and the decoded {data, error} result with its valid strobe.
interface odd_parity_checker_if
    import odd_parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              clr;
    logic              in;
    logic              in_valid;
    logic [DATA_W-1:0] data_out;
    logic              parity_err;
    logic              out_valid;
    logic              busy;

    modport master (
        output clr, in, in_valid,
        input  data_out, parity_err, out_valid, busy
    );

    modport slave (
        input  clr, in, in_valid,
        output data_out, parity_err, out_valid, busy
    );

endinterface

// File: rtl/odd_parity_checker.sv
// Serial odd-parity receiver: shifts in DATA_W bits MSB first, then checks the
// trailing parity bit and reports the word with a one-cycle valid pulse.
module odd_parity_checker
    import odd_parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    odd_parity_checker_if.slave  link
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [DATA_W-1:0]  shift_r;
    logic               acc_r;
    logic [DATA_W-1:0]  data_out_r;
    logic               parity_err_r;
    logic               out_valid_r;

    // Widened concat keeps the shift legal even for a single-bit word.
    logic [DATA_W:0]    shift_cat_s;
    logic [DATA_W-1:0]  shift_next_s;

    assign shift_cat_s  = {shift_r, link.in};
    assign shift_next_s = shift_cat_s[DATA_W-1:0];

    // Frame FSM, deserialiser, parity accumulator and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_DATA;
            bit_cnt_r    <= {CNT_W{1'b0}};
            shift_r      <= {DATA_W{1'b0}};
            acc_r        <= 1'b0;
            data_out_r   <= {DATA_W{1'b0}};
            parity_err_r <= 1'b0;
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (link.clr) begin
                state_r   <= S_DATA;
                bit_cnt_r <= {CNT_W{1'b0}};
                shift_r   <= {DATA_W{1'b0}};
                acc_r     <= 1'b0;
            end else if (link.in_valid) begin
                case (state_r)
                    S_DATA: begin
                        shift_r   <= shift_next_s;
                        acc_r     <= acc_r ^ link.in;
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        if (bit_cnt_r == LAST_CNT) begin
                            state_r <= S_PAR;
                        end else begin
                            state_r <= S_DATA;
                        end
                    end
                    S_PAR: begin
                        data_out_r   <= shift_r;
                        parity_err_r <= ~(acc_r ^ link.in);
                        out_valid_r  <= 1'b1;
                        acc_r        <= 1'b0;
                        bit_cnt_r    <= {CNT_W{1'b0}};
                        state_r      <= S_DATA;
                    end
                    default: begin
                        state_r   <= S_DATA;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        shift_r   <= {DATA_W{1'b0}};
                        acc_r     <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign link.data_out   = data_out_r;
    assign link.parity_err = parity_err_r;
    assign link.out_valid  = out_valid_r;
    assign link.busy       = (bit_cnt_r != {CNT_W{1'b0}});

endmodule

// File: tb/tb_odd_parity_checker.sv
// Directed bench for odd_parity_checker (DATA_W=3): hand-computed frame table
// plus short sequences for gaps, abort and asynchronous reset.
module tb_odd_parity_checker;
    import odd_parity_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    odd_parity_checker_if #(.DATA_W(3)) link();

    odd_parity_checker #(.DATA_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .link  (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] data;
        logic       par;
        logic       exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the next rising edge.
    task automatic step(input logic b, input logic v, input logic c);
        link.in       = b;
        link.in_valid = v;
        link.clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_data(input logic [2:0] d);
        for (int i = 2; i >= 0; i--) step(d[i], 1'b1, 1'b0);
    endtask

    task automatic expect_frame(input string name, input logic [2:0] d, input logic e);
        check({name, "_valid"}, 32'(link.out_valid), 32'd1);
        check({name, "_data"}, 32'(link.data_out), 32'(d));
        check({name, "_err"}, 32'(link.parity_err), 32'(e));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // {data, parity bit, expected error}: frame is good when total ones is odd
        vecs[0]  = '{3'b000, 1'b1, 1'b0};  vecs[1]  = '{3'b000, 1'b0, 1'b1};
        vecs[2]  = '{3'b001, 1'b0, 1'b0};  vecs[3]  = '{3'b001, 1'b1, 1'b1};
        vecs[4]  = '{3'b010, 1'b0, 1'b0};  vecs[5]  = '{3'b010, 1'b1, 1'b1};
        vecs[6]  = '{3'b011, 1'b1, 1'b0};  vecs[7]  = '{3'b011, 1'b0, 1'b1};
        vecs[8]  = '{3'b100, 1'b0, 1'b0};  vecs[9]  = '{3'b100, 1'b1, 1'b1};
        vecs[10] = '{3'b101, 1'b1, 1'b0};  vecs[11] = '{3'b101, 1'b0, 1'b1};
        vecs[12] = '{3'b110, 1'b1, 1'b0};  vecs[13] = '{3'b110, 1'b0, 1'b1};
        vecs[14] = '{3'b111, 1'b0, 1'b0};  vecs[15] = '{3'b111, 1'b1, 1'b1};

        reset         = 1'b0;
        link.in       = 1'b0;
        link.in_valid = 1'b0;
        link.clr      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", 32'(link.data_out), 32'd0);
        check("rst_err", 32'(link.parity_err), 32'd0);
        check("rst_valid", 32'(link.out_valid), 32'd0);
        check("rst_busy", 32'(link.busy), 32'd0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Test 1: 101 + parity 1
        send_data(3'b101);
        check("t1_busy_par", 32'(link.busy), 32'd1);
        check("t1_novalid", 32'(link.out_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        expect_frame("t1", 3'b101, 1'b0);
        check("t1_busy_done", 32'(link.busy), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("t1_pulse_end", 32'(link.out_valid), 32'd0);

        // Test 2: 101 + parity 0
        send_data(3'b101);
        step(1'b0, 1'b1, 1'b0);
        expect_frame("t2", 3'b101, 1'b1);

        // Test 3: back-to-back 000+1 then 111+0
        send_data(3'b000);
        step(1'b1, 1'b1, 1'b0);
        expect_frame("t3a", 3'b000, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("t3_first_bit_ok", 32'(link.busy), 32'd1);
        check("t3_pulse_gap", 32'(link.out_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("t3_pulse_gap2", 32'(link.out_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        expect_frame("t3b", 3'b111, 1'b0);

        // Test 4: abort after two bits, with a bit offered in the clr cycle
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("t4_clr_busy", 32'(link.busy), 32'd0);
        check("t4_clr_valid", 32'(link.out_valid), 32'd0);
        check("t4_clr_hold", 32'(link.data_out), 32'd7);
        send_data(3'b010);
        check("t4_hold_pre", 32'(link.data_out), 32'd7);
        step(1'b0, 1'b1, 1'b0);
        expect_frame("t4", 3'b010, 1'b0);

        // Abort while waiting for the parity bit: no frame reported
        send_data(3'b110);
        step(1'b1, 1'b1, 1'b1);
        check("t4p_valid", 32'(link.out_valid), 32'd0);
        check("t4p_busy", 32'(link.busy), 32'd0);
        check("t4p_hold", 32'(link.data_out), 32'd2);

        // Test 5: bit 0, 5-cycle gap, then 1,1 + parity 1
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("t5_gap_busy%0d", i), 32'(link.busy), 32'd1);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        expect_frame("t5", 3'b011, 1'b0);

        // Test 6: asynchronous reset mid-frame, between clock edges
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        link.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t6_data", 32'(link.data_out), 32'd0);
        check("t6_err", 32'(link.parity_err), 32'd0);
        check("t6_busy", 32'(link.busy), 32'd0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_data(3'b110);
        step(1'b1, 1'b1, 1'b0);
        expect_frame("t6", 3'b110, 1'b0);

        // Table sweep: every word with correct and flipped parity, back-to-back
        for (int k = 0; k < 16; k++) begin
            send_data(vecs[k].data);
            check($sformatf("sweep%0d_pre", k), 32'(link.out_valid), 32'd0);
            step(vecs[k].par, 1'b1, 1'b0);
            expect_frame($sformatf("sweep%0d", k), vecs[k].data, vecs[k].exp_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
